// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: FU requests in, scoreboard writeback ports out.
// master = FU/scoreboard side, slave = arbiter.
interface wb_port_arbiter_if #(
   parameter int N_REQ         = 5,
   parameter int N_PORTS       = 3,
   parameter int TRANS_ID_BITS = 2
);
   logic                             flush_i;
   logic [N_REQ-1:0]                 req_valid_i;
   logic [N_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i;
   logic [N_REQ*64-1:0]              req_result_i;
   logic [N_REQ-1:0]                 req_ex_valid_i;
   logic [N_REQ-1:0]                 req_ready_o;
   logic [N_PORTS-1:0]               wb_valid_o;
   logic [N_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o;
   logic [N_PORTS*64-1:0]            wb_result_o;
   logic [N_PORTS-1:0]               wb_ex_valid_o;
   logic [N_PORTS*3-1:0]             wb_src_o;
   logic [15:0]                      conflict_cnt_o;

   modport master (
      output flush_i, req_valid_i, req_trans_id_i,
      output req_result_i, req_ex_valid_i,
      input  req_ready_o, wb_valid_o, wb_trans_id_o,
      input  wb_result_o, wb_ex_valid_o, wb_src_o,
      input  conflict_cnt_o
   );

   modport slave (
      input  flush_i, req_valid_i, req_trans_id_i,
      input  req_result_i, req_ex_valid_i,
      output req_ready_o, wb_valid_o, wb_trans_id_o,
      output wb_result_o, wb_ex_valid_o, wb_src_o,
      output conflict_cnt_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter of FU results onto the scoreboard writeback ports.
// Define WB_ARB_EXC_PRIO_EN to grant exception results ahead of others.
module wb_port_arbiter #(
   parameter int N_REQ         = 5,
   parameter int N_PORTS       = 3,
   parameter int TRANS_ID_BITS = 2
) (
   input logic              clk_i,
   input logic              rst_ni,
   wb_port_arbiter_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(N_PORTS + 1);
   localparam int TW = TRANS_ID_BITS;

   logic [PW-1:0]           ptr_q, ptr_d;
   logic [N_REQ-1:0]        gnt;
   logic [CW-1:0]           gnt_cnt;
   logic [PW-1:0]           gnt_idx [N_PORTS];
   logic [N_PORTS-1:0]      wb_valid_q;
   logic [N_PORTS*TW-1:0]   wb_tid_q;
   logic [N_PORTS*64-1:0]   wb_res_q;
   logic [N_PORTS-1:0]      wb_ex_q;
   logic [N_PORTS*3-1:0]    wb_src_q;
   logic [15:0]             cnt_q;
   logic                    conflict;

   // Scan from ptr_q, optionally exceptions first; the k-th hit goes to port k
   always_comb begin : grant
      int         j;
      logic [PW-1:0] idx;
      logic       sel;
      j       = 0;
      idx     = '0;
      sel     = 1'b0;
      gnt     = '0;
      gnt_cnt = '0;
      ptr_d   = ptr_q;
      for (int p = 0; p < N_PORTS; p++) gnt_idx[p] = '0;
      if (!bus.flush_i) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N_REQ; k++) begin
               j = int'(ptr_q) + k;
               if (j >= N_REQ) j = j - N_REQ;
               idx = PW'(j);
`ifdef WB_ARB_EXC_PRIO_EN
               sel = bus.req_valid_i[idx] &&
                     (bus.req_ex_valid_i[idx] == (pass == 0));
`else
               sel = bus.req_valid_i[idx] && (pass == 0);
`endif
               if (sel && (gnt_cnt < CW'(N_PORTS))) begin
                  gnt[idx]         = 1'b1;
                  gnt_idx[gnt_cnt] = idx;
                  gnt_cnt          = gnt_cnt + 1'b1;
                  ptr_d = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
               end
            end
         end
      end
   end

   assign conflict = !bus.flush_i &&
                     ($countones(bus.req_valid_i) > N_PORTS);

   assign bus.req_ready_o    = rst_ni ? gnt : '0;
   assign bus.wb_valid_o     = wb_valid_q;
   assign bus.wb_trans_id_o  = wb_tid_q;
   assign bus.wb_result_o    = wb_res_q;
   assign bus.wb_ex_valid_o  = wb_ex_q;
   assign bus.wb_src_o       = wb_src_q;
   assign bus.conflict_cnt_o = cnt_q;

   // Register granted results; unused ports drop valid but keep data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         cnt_q      <= '0;
         wb_valid_q <= '0;
         wb_tid_q   <= '0;
         wb_res_q   <= '0;
         wb_ex_q    <= '0;
         wb_src_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (conflict && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
         for (int p = 0; p < N_PORTS; p++) begin
            if (CW'(p) < gnt_cnt) begin
               wb_valid_q[p]         <= 1'b1;
               wb_tid_q[p*TW +: TW]  <=
                  bus.req_trans_id_i[gnt_idx[p]*TW +: TW];
               wb_res_q[p*64 +: 64]  <=
                  bus.req_result_i[gnt_idx[p]*64 +: 64];
               wb_ex_q[p]            <= bus.req_ex_valid_i[gnt_idx[p]];
               wb_src_q[p*3 +: 3]    <= 3'(gnt_idx[p]);
            end else begin
               wb_valid_q[p] <= 1'b0;
            end
         end
      end
   end
endmodule
